// File: rtl/note_image_sched_pkg.sv
// Shared definitions for the note-image display path: scheduler states,
// display-window geometry and image indices used by tone generator and RGB mux.
package note_image_sched_pkg;

   localparam int unsigned REQ_W   = 8;
   localparam int unsigned NOTE_W  = 4;
   localparam int unsigned COORD_W = 10;
   localparam int unsigned ADDR_W  = 16;
   localparam int unsigned HOLD_W  = 8;

   localparam int unsigned Y_TOP = 125;
   localparam int unsigned Y_BOT = 355;
   localparam int unsigned X_END = 640;
   localparam int unsigned IMG_W = 320;

   localparam logic [NOTE_W-1:0] IMG_IDLE = 4'd0;
   localparam logic [NOTE_W-1:0] IMG_M1   = 4'd1;
   localparam logic [NOTE_W-1:0] IMG_M2   = 4'd2;
   localparam logic [NOTE_W-1:0] IMG_M3   = 4'd3;
   localparam logic [NOTE_W-1:0] IMG_M4   = 4'd4;
   localparam logic [NOTE_W-1:0] IMG_M5   = 4'd5;
   localparam logic [NOTE_W-1:0] IMG_M6   = 4'd6;
   localparam logic [NOTE_W-1:0] IMG_M7   = 4'd7;
   localparam logic [NOTE_W-1:0] IMG_H1   = 4'd8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LIVE = 2'd1,
      ST_AUTO = 2'd2,
      ST_HOLD = 2'd3
   } sched_state_e;

endpackage

// File: rtl/note_prio_enc.sv
// Lowest-set-bit encoder: request bit i maps to note i+1, no request maps to 0.
module note_prio_enc
   import note_image_sched_pkg::*;
(
   input  logic [REQ_W-1:0]  req_i,
   output logic [NOTE_W-1:0] note_c_o
);

   // Scan high to low so the lowest set bit is written last and wins.
   always_comb begin
      note_c_o = IMG_IDLE;
      for (int i = REQ_W - 1; i >= 0; i--) begin
         if (req_i[i]) note_c_o = NOTE_W'(i + 1);
      end
   end

endmodule

// File: rtl/note_image_sched.sv
// Note-image scheduler: arbitrates keyboard vs autoplay, holds the last note after
// release, commits images on frame boundaries and generates the BRAM read address.
module note_image_sched #(
   parameter int unsigned HOLD_FRAMES = 30,
   parameter int unsigned Y_TOP       = note_image_sched_pkg::Y_TOP,
   parameter int unsigned Y_BOT       = note_image_sched_pkg::Y_BOT,
   parameter int unsigned X_END       = note_image_sched_pkg::X_END,
   parameter int unsigned IMG_W       = note_image_sched_pkg::IMG_W
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic [note_image_sched_pkg::REQ_W-1:0]     key_req,
   input  logic                                       auto_en,
   input  logic [note_image_sched_pkg::REQ_W-1:0]     auto_req,
   input  logic [note_image_sched_pkg::COORD_W-1:0]   x_counter,
   input  logic [note_image_sched_pkg::COORD_W-1:0]   y_counter,
   output logic [note_image_sched_pkg::NOTE_W-1:0]    img_sel,
   output logic [note_image_sched_pkg::ADDR_W-1:0]    addr,
   output logic                                       addr_valid,
   output logic                                       frame_tick,
   output logic                                       busy_auto
);

   import note_image_sched_pkg::*;

   sched_state_e        state_q, state_d;
   logic [NOTE_W-1:0]   tgt_q, tgt_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic                from_auto_q, from_auto_d;
   logic [NOTE_W-1:0]   img_sel_q, img_sel_d;
   logic                busy_auto_q, busy_auto_d;
   logic [COORD_W-1:0]  prev_y_q;
   logic                frame_tick_q, frame_tick_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                addr_valid_q, addr_valid_d;

   logic [REQ_W-1:0]    auto_req_c;
   logic [NOTE_W-1:0]   key_note_c, auto_note_c;
   logic                key_hit_c, auto_hit_c, expire_c, in_win_c;
   logic [ADDR_W-1:0]   row_c;

   assign auto_req_c = auto_req & {REQ_W{auto_en}};

   note_prio_enc u_key_enc (
      .req_i    (key_req),
      .note_c_o (key_note_c)
   );

   note_prio_enc u_auto_enc (
      .req_i    (auto_req_c),
      .note_c_o (auto_note_c)
   );

   assign key_hit_c  = (key_note_c != IMG_IDLE);
   assign auto_hit_c = (auto_note_c != IMG_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         tgt_q        <= IMG_IDLE;
         hold_q       <= '0;
         from_auto_q  <= 1'b0;
         img_sel_q    <= IMG_IDLE;
         busy_auto_q  <= 1'b0;
         prev_y_q     <= '0;
         frame_tick_q <= 1'b0;
         addr_q       <= '0;
         addr_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         tgt_q        <= tgt_d;
         hold_q       <= hold_d;
         from_auto_q  <= from_auto_d;
         img_sel_q    <= img_sel_d;
         busy_auto_q  <= busy_auto_d;
         prev_y_q     <= y_counter;
         frame_tick_q <= frame_tick_d;
         addr_q       <= addr_d;
         addr_valid_q <= addr_valid_d;
      end
   end

   // Arbitration, hold countdown and frame-synchronous commit.
   always_comb begin
      state_d     = state_q;
      tgt_d       = tgt_q;
      hold_d      = hold_q;
      from_auto_d = from_auto_q;
      expire_c    = 1'b0;
      img_sel_d   = img_sel_q;
      busy_auto_d = busy_auto_q;

      if (key_hit_c) begin
         state_d = ST_LIVE;
         tgt_d   = key_note_c;
      end else if (auto_hit_c) begin
         state_d = ST_AUTO;
         tgt_d   = auto_note_c;
      end else begin
         unique case (state_q)
            ST_IDLE: tgt_d = IMG_IDLE;
            ST_LIVE,
            ST_AUTO: begin
               state_d     = ST_HOLD;
               hold_d      = HOLD_W'(HOLD_FRAMES);
               from_auto_d = (state_q == ST_AUTO);
            end
            ST_HOLD: begin
               if (frame_tick_q) begin
                  if (hold_q <= HOLD_W'(1)) begin
                     state_d  = ST_IDLE;
                     tgt_d    = IMG_IDLE;
                     hold_d   = '0;
                     expire_c = 1'b1;
                  end else begin
                     hold_d = hold_q - HOLD_W'(1);
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      // The expiring tick already shows the idle picture.
      if (frame_tick_q) begin
         img_sel_d   = expire_c ? IMG_IDLE : tgt_q;
         busy_auto_d = !expire_c &&
                       ((state_q == ST_AUTO) || ((state_q == ST_HOLD) && from_auto_q));
      end
   end

   // Frame boundary detection and 2x2-doubled BRAM address.
   always_comb begin
      frame_tick_d = (y_counter == '0) && (prev_y_q != '0);
      in_win_c     = (x_counter < COORD_W'(X_END)) &&
                     (y_counter >= COORD_W'(Y_TOP)) &&
                     (y_counter < COORD_W'(Y_BOT));
      row_c        = ADDR_W'((y_counter - COORD_W'(Y_TOP)) >> 1);
      addr_d       = addr_q;
      addr_valid_d = 1'b0;
      if (in_win_c) begin
         addr_d       = row_c * ADDR_W'(IMG_W) + ADDR_W'(x_counter >> 1);
         addr_valid_d = 1'b1;
      end
   end

   assign img_sel    = img_sel_q;
   assign addr       = addr_q;
   assign addr_valid = addr_valid_q;
   assign frame_tick = frame_tick_q;
   assign busy_auto  = busy_auto_q;

endmodule

// File: tb/tb_note_image_sched.sv
// Randomized self-checking bench for note_image_sched against a behavioural
// model of the visible-note / hold / commit / address rules.
module tb_note_image_sched;

   localparam int unsigned HF = 3;

   logic       clk;
   logic       rst;
   logic [7:0] key_req;
   logic       auto_en;
   logic [7:0] auto_req;
   logic [9:0] x_counter;
   logic [9:0] y_counter;
   logic [3:0] img_sel;
   logic [15:0] addr;
   logic       addr_valid;
   logic       frame_tick;
   logic       busy_auto;

   note_image_sched #(.HOLD_FRAMES(HF)) dut (
      .clk        (clk),
      .rst        (rst),
      .key_req    (key_req),
      .auto_en    (auto_en),
      .auto_req   (auto_req),
      .x_counter  (x_counter),
      .y_counter  (y_counter),
      .img_sel    (img_sel),
      .addr       (addr),
      .addr_valid (addr_valid),
      .frame_tick (frame_tick),
      .busy_auto  (busy_auto)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
   endtask

   // Model: what is on screen, where it came from, and how many frames remain.
   int m_tgt = 0, m_auto_src = 0, m_released = 0, m_hold = 0;
   int m_prev_y = 0, m_tick = 0, m_img = 0, m_busy = 0, m_addr = 0, m_av = 0;

   function automatic int lowest_note(input logic [7:0] v);
      for (int i = 0; i < 8; i++) if (v[i]) return i + 1;
      return 0;
   endfunction

   task automatic model_edge();
      int kn, an, yy, xx, tick, expire;
      yy = int'(y_counter);
      xx = int'(x_counter);
      if (rst) begin
         m_tgt = 0; m_auto_src = 0; m_released = 0; m_hold = 0;
         m_prev_y = 0; m_tick = 0; m_img = 0; m_busy = 0; m_addr = 0; m_av = 0;
         return;
      end
      tick   = m_tick;
      kn     = lowest_note(key_req);
      an     = auto_en ? lowest_note(auto_req) : 0;
      expire = (kn == 0 && an == 0 && m_tgt != 0 && m_released != 0 &&
                tick != 0 && m_hold <= 1) ? 1 : 0;
      if (tick != 0) begin
         m_img  = expire ? 0 : m_tgt;
         m_busy = (expire == 0 && m_auto_src != 0 && m_tgt != 0) ? 1 : 0;
      end
      if (kn != 0) begin
         m_tgt = kn; m_auto_src = 0; m_released = 0;
      end else if (an != 0) begin
         m_tgt = an; m_auto_src = 1; m_released = 0;
      end else if (m_tgt != 0) begin
         if (m_released == 0) begin
            m_released = 1;
            m_hold     = HF;
         end else if (tick != 0) begin
            if (expire != 0) begin
               m_tgt = 0; m_released = 0;
            end else begin
               m_hold--;
            end
         end
      end
      m_tick   = (yy == 0 && m_prev_y != 0) ? 1 : 0;
      m_prev_y = yy;
      if (xx < 640 && yy >= 125 && yy < 355) begin
         m_addr = ((yy - 125) / 2) * 320 + xx / 2;
         m_av   = 1;
      end else begin
         m_av = 0;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      check_val("img_sel", img_sel, m_img);
      check_val("busy_auto", busy_auto, m_busy);
      check_val("frame_tick", frame_tick, m_tick);
      check_val("addr_valid", addr_valid, m_av);
      check_val("addr", addr, m_addr);
   endtask

   // Compressed raster: a few representative lines, 3 cycles each, random columns.
   int lines[15] = '{0, 0, 1, 60, 124, 125, 126, 127, 240, 353, 354, 355, 356, 480, 524};
   int pos = 0;

   task automatic drive_raster();
      int r;
      y_counter = 10'(lines[(pos / 3) % 15]);
      r = $urandom_range(0, 7);
      case (r)
         0:       x_counter = 10'd0;
         1:       x_counter = 10'd1;
         2:       x_counter = 10'd638;
         3:       x_counter = 10'd639;
         4:       x_counter = 10'd640;
         5:       x_counter = 10'd1023;
         default: x_counter = 10'($urandom_range(0, 799));
      endcase
      pos++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         drive_raster();
         cycle();
      end
   endtask

   // Advance through the next frame tick and the commit edge that follows it.
   task automatic next_commit();
      for (int i = 0; i < 200; i++) begin
         drive_raster();
         cycle();
         if (m_tick != 0) begin
            drive_raster();
            cycle();
            return;
         end
      end
      check_val("tick_timeout", 0, 1);
   endtask

   initial begin
      rst = 1'b1; key_req = '0; auto_en = 1'b0; auto_req = '0;
      x_counter = '0; y_counter = '0;
      run(3);
      check_val("rst_img", img_sel, 0);
      check_val("rst_valid", addr_valid, 0);
      rst = 1'b0;
      run(100);
      check_val("idle_img", img_sel, 0);

      // Window corners.
      x_counter = 10'd0; y_counter = 10'd125; cycle();
      check_val("addr_first", addr, 0);
      check_val("addr_first_v", addr_valid, 1);
      x_counter = 10'd639; y_counter = 10'd354; cycle();
      check_val("addr_last", addr, 36799);
      x_counter = 10'd640; y_counter = 10'd200; cycle();
      check_val("addr_xend_v", addr_valid, 0);
      check_val("addr_hold", addr, 36799);
      x_counter = 10'd10; y_counter = 10'd355; cycle();
      check_val("addr_ybot_v", addr_valid, 0);

      // Key mid-frame: nothing visible until the tick.
      run(10);
      key_req = 8'b0000_0100;
      run(1);
      check_val("key_pre_tick", img_sel, 0);
      next_commit();
      check_val("key_commit", img_sel, 3);
      check_val("key_busy", busy_auto, 0);

      // Keyboard pre-empts autoplay; autoplay takes over when keys drop.
      auto_en = 1'b1; auto_req = 8'h10; key_req = 8'h01;
      next_commit();
      check_val("kbd_wins", img_sel, 1);
      key_req = 8'h00;
      next_commit();
      check_val("auto_commit", img_sel, 5);
      check_val("auto_busy", busy_auto, 1);

      // Release: held two ticks, idle on the third.
      auto_req = 8'h00; auto_en = 1'b0;
      next_commit(); check_val("hold_t1", img_sel, 5);
      next_commit(); check_val("hold_t2", img_sel, 5);
      next_commit(); check_val("hold_t3", img_sel, 0);
      check_val("hold_t3_busy", busy_auto, 0);

      // Short pulse between ticks, then a new key during hold.
      run(10);
      key_req = 8'h20; run(10); key_req = 8'h00;
      next_commit(); check_val("pulse_t1", img_sel, 6);
      next_commit(); check_val("pulse_t2", img_sel, 6);
      key_req = 8'h80; run(5); key_req = 8'h00;
      next_commit(); check_val("hold_newkey", img_sel, 8);

      // Reset while live.
      key_req = 8'h02;
      next_commit();
      run(10);
      rst = 1'b1;
      drive_raster(); cycle();
      check_val("mid_rst_img", img_sel, 0);
      check_val("mid_rst_tick", frame_tick, 0);
      check_val("mid_rst_addr", addr, 0);
      rst = 1'b0; key_req = 8'h00;
      run(100);
      check_val("post_rst_img", img_sel, 0);

      // Random traffic.
      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(0, 39) == 0)
            key_req = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
         if ($urandom_range(0, 29) == 0) begin
            auto_req = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'h00;
            auto_en  = ($urandom_range(0, 3) != 0);
         end
         rst = ($urandom_range(0, 999) == 0);
         drive_raster();
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
